dl_skid_buf: RTL and testbench

//   Two-entry valid/ready skid buffer: the consumer-facing read side of an enable-loaded register.

---
 rtl/dl_pkg.sv | 11 +
 rtl/dl_skid_buf_if.sv | 22 ++
 rtl/dl_reg_en_rst.sv | 22 ++
 rtl/dl_skid_buf.sv | 124 ++++++++++++
 tb/tb_dl_skid_buf.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dl_pkg.sv
// Shared types for the dl_skid_buf skid buffer.
package dl_pkg;

    // State encoding doubles as the occupancy count; 2'd3 is unused.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_FULL  = 2'd2
    } dl_skid_state_t;

endpackage

// File: rtl/dl_skid_buf_if.sv
// Handshake bundle for dl_skid_buf: upstream push side, downstream pop side, occupancy.
interface dl_skid_buf_if #(
    parameter int unsigned NUM_BITS = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] out_data;
    logic [1:0]          occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/dl_reg_en_rst.sv
// Enable-loaded register with synchronous active-low reset to RST_VAL.
module dl_reg_en_rst #(
    parameter int unsigned         NUM_BITS = 32,
    parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_BITS-1:0] d,
    output logic [NUM_BITS-1:0] q
);

    // Reset dominates the load enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready depends only on state and rst;
// out_valid/out_data/occupancy are decoded from registered state only.
module dl_skid_buf
    import dl_pkg::*;
#(
    parameter int unsigned         NUM_BITS = 32,
    parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    dl_skid_buf_if.slave  bus
);

    dl_skid_state_t      state_q;
    dl_skid_state_t      state_d;
    logic                in_ready;
    logic                out_valid;
    logic                push;
    logic                pop;
    logic                load_main;
    logic                load_skid;
    logic                main_from_skid;
    logic [NUM_BITS-1:0] main_d;
    logic [NUM_BITS-1:0] main_q;
    logic [NUM_BITS-1:0] skid_q;

    // State register; reset discards any held beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake decode, next state and data-register load strobes.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;

        case (state_q)
            SB_EMPTY: begin
                in_ready = ~rst;
            end
            SB_ONE: begin
                in_ready  = ~rst;
                out_valid = 1'b1;
            end
            SB_FULL: begin
                out_valid = 1'b1;
            end
            default: ;
        endcase

        push = bus.in_valid & in_ready;
        pop  = out_valid & bus.out_ready;

        case (state_q)
            SB_EMPTY: begin
                if (push) begin
                    state_d   = SB_ONE;
                    load_main = 1'b1;
                end
            end
            SB_ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    state_d   = SB_FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d   = SB_EMPTY;
                end
            end
            SB_FULL: begin
                if (pop) begin
                    state_d        = SB_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = SB_EMPTY;
            end
        endcase
    end

    // Main register refills from the skid slot when draining out of FULL.
    always_comb begin
        main_d = main_from_skid ? skid_q : bus.in_data;
    end

    dl_reg_en_rst #(
        .NUM_BITS (NUM_BITS),
        .RST_VAL  (RST_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (~rst),
        .en    (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    dl_reg_en_rst #(
        .NUM_BITS (NUM_BITS),
        .RST_VAL  (RST_VAL)
    ) u_skid (
        .clk   (clk),
        .rst_n (~rst),
        .en    (load_skid),
        .d     (bus.in_data),
        .q     (skid_q)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

endmodule

// File: tb/tb_dl_skid_buf.sv
// Self-checking bench for dl_skid_buf: directed scenarios plus a randomized
// run against a queue-based reference model, with protocol monitors.
module tb_dl_skid_buf;

    localparam logic [31:0] TB_RST = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    dl_skid_buf_if #(.NUM_BITS(32)) bus ();

    dl_skid_buf #(
        .NUM_BITS (32),
        .RST_VAL  (TB_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of depth 2 driven purely by the handshake rules.
    logic [31:0] mq[$];
    bit          m_push = 1'b0;
    bit          m_pop  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_push = 1'b0;
            m_pop  = 1'b0;
        end else begin
            m_push = bus.in_valid && (mq.size() < 2);
            m_pop  = bus.out_ready && (mq.size() > 0);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(bus.in_data);
        end
    end

    // Protocol monitors on both sides plus the illegal-encoding check.
    bit          mon_en = 1'b0;
    logic        p_ov = 1'b0, p_pop = 1'b0, p_rst = 1'b1;
    logic        p_iv = 1'b0, p_push = 1'b0;
    logic [31:0] p_od = '0, p_id = '0;

    always @(posedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.occupancy === 2'd3) begin
                failures++;
                $display("FAIL illegal_state occupancy=%0d", bus.occupancy);
            end
            if (!p_rst && p_ov && !p_pop) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== p_od) begin
                    failures++;
                    $display("FAIL out_hold got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, p_od);
                end
            end
            if (!p_rst && p_iv && !p_push) begin
                checks++;
                if (bus.in_valid !== 1'b1 || bus.in_data !== p_id) begin
                    failures++;
                    $display("FAIL in_hold got v=%b d=%h exp v=1 d=%h", bus.in_valid, bus.in_data, p_id);
                end
            end
        end
        p_ov   = bus.out_valid;
        p_od   = bus.out_data;
        p_pop  = bus.out_valid && bus.out_ready;
        p_iv   = bus.in_valid;
        p_id   = bus.in_data;
        p_push = bus.in_valid && bus.in_ready;
        p_rst  = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.occupancy !== 2'd0) begin
            failures++;
            $display("FAIL rst_occupancy got=%0d exp=0", bus.occupancy);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.out_data !== TB_RST) begin
            failures++;
            $display("FAIL rst_out_data got=%h exp=%h", bus.out_data, TB_RST);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'h1, 32'h2, 32'h3};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = vals[i];
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i] || bus.occupancy !== 2'd1) begin
                failures++;
                $display("FAIL b2b_beat%0d got v=%b d=%h occ=%0d exp v=1 d=%h occ=1",
                         i, bus.out_valid, bus.out_data, bus.occupancy, vals[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            failures++;
            $display("FAIL b2b_drain got v=%b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_full_stall();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        tick();
        checks++;
        if (bus.occupancy !== 2'd1 || bus.out_data !== 32'hA) begin
            failures++;
            $display("FAIL stall_one got occ=%0d d=%h exp occ=1 d=a", bus.occupancy, bus.out_data);
        end
        bus.in_data = 32'hB;
        tick();
        checks++;
        if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
            failures++;
            $display("FAIL stall_full got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=a",
                     bus.occupancy, bus.in_ready, bus.out_data);
        end
    endtask

    task automatic test_full_hold();
        bus.in_data = 32'hC;
        tick();
        checks++;
        if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
            failures++;
            $display("FAIL hold_full got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=a",
                     bus.occupancy, bus.in_ready, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_data !== 32'hB) begin
            failures++;
            $display("FAIL hold_pop_a got occ=%0d rdy=%b d=%h exp occ=1 rdy=1 d=b",
                     bus.occupancy, bus.in_ready, bus.out_data);
        end
        tick();
        checks++;
        if (bus.occupancy !== 2'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hC) begin
            failures++;
            $display("FAIL hold_pop_b got occ=%0d v=%b d=%h exp occ=1 v=1 d=c",
                     bus.occupancy, bus.out_valid, bus.out_data);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_drain got occ=%0d v=%b exp occ=0 v=0", bus.occupancy, bus.out_valid);
        end
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h55;
        tick();
        bus.in_data = 32'h66;
        tick();
        checks++;
        if (bus.occupancy !== 2'd2) begin
            failures++;
            $display("FAIL rfull_fill got occ=%0d exp=2", bus.occupancy);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rfull_in_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || bus.out_data !== TB_RST) begin
            failures++;
            $display("FAIL rfull_release got occ=%0d v=%b rdy=%b d=%h exp occ=0 v=0 rdy=1 d=%h",
                     bus.occupancy, bus.out_valid, bus.in_ready, bus.out_data, TB_RST);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        tick();
        checks++;
        if (bus.occupancy !== 2'd1 || bus.out_data !== 32'h77) begin
            failures++;
            $display("FAIL rfull_restart got occ=%0d d=%h exp occ=1 d=77", bus.occupancy, bus.out_data);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit hold;
        bit rst_fail_seen = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            hold = bus.in_valid && !m_push && !rst;
            rst  = ($urandom_range(0, 99) < 5);
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 99) < 60);
                bus.in_data  = $urandom;
            end
            bus.out_ready = ($urandom_range(0, 99) < 65);
            #1;
            checks++;
            if (bus.occupancy !== 2'(mq.size())) begin
                failures++;
                if (!rst_fail_seen) $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", cyc, bus.occupancy, mq.size());
                rst_fail_seen = 1'b1;
            end
            checks++;
            if (bus.out_valid !== (mq.size() > 0)) begin
                failures++;
                $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, mq.size() > 0);
            end
            checks++;
            if (bus.in_ready !== (!rst && mq.size() < 2)) begin
                failures++;
                $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, !rst && mq.size() < 2);
            end
            if (mq.size() > 0) begin
                checks++;
                if (bus.out_data !== mq[0]) begin
                    failures++;
                    $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, mq[0]);
                end
            end
            tick();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_full_hold();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
